// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer slice.
package piso_pkg;

  localparam int PISO_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-in / serial-out handshake bundle. The master side feeds words and
// consumes bits. The slave side is the serializer.
interface piso_serializer_if
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
);
  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic             out;
  logic             out_valid;
  logic             ser_ready;
  logic             frame_done;

  modport master (
    output data_in, in_valid, ser_ready,
    input  in_ready, out, out_valid, frame_done
  );

  modport slave (
    input  data_in, in_valid, ser_ready,
    output in_ready, out, out_valid, frame_done
  );
endinterface

// File: rtl/piso_bit_counter.sv
// Data-bit position counter: cleared on word load, advances on each consumed
// data bit, and saturates at the last index so it never wraps inside a frame.
module piso_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic last
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             count <= '0;
    else if (clear)         count <= '0;
    else if (inc && !last)  count <= count + CW'(1);
  end

  assign last = (count == LAST_IDX);
endmodule

// File: rtl/piso_serializer.sv
// Parallel-to-serial converter with valid/ready on both sides and zero-bubble
// back-to-back frames. Define PISO_PARITY_EN to append an even-parity bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               reset_n,
  piso_serializer_if.slave  bus
);
  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic             last;
  logic             out_valid;
  logic             in_ready;
  logic             out_bit;
  logic             accept;
  logic             consume;
  logic             shift_consume;
  logic             final_consume;
  logic             frame_done;

  assign consume       = out_valid && bus.ser_ready;
  assign shift_consume = consume && (state == SHIFT);
  assign accept        = bus.in_valid && in_ready;

`ifdef PISO_PARITY_EN
  logic parity;
  assign final_consume = consume && (state == PARITY);
`else
  assign final_consume = shift_consume && last;
`endif

  piso_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (accept),
    .inc   (shift_consume),
    .last  (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
`ifdef PISO_PARITY_EN
      SHIFT:  if (shift_consume && last) state_nxt = PARITY;
      PARITY: if (consume) state_nxt = accept ? SHIFT : IDLE;
`else
      SHIFT:  if (final_consume) state_nxt = accept ? SHIFT : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Ready also rises on the final consume so the next word chains in directly.
  always_comb begin
    out_valid = (state != IDLE);
    in_ready  = (state == IDLE) || final_consume;
    out_bit   = 1'b0;
    if (state == SHIFT) out_bit = MSB_FIRST ? sr[WIDTH-1] : sr[0];
`ifdef PISO_PARITY_EN
    else if (state == PARITY) out_bit = parity;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr         <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= final_consume;
      if (accept)
        sr <= bus.data_in;
      else if (shift_consume)
        sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    parity <= 1'b0;
    else if (accept) parity <= ^bus.data_in;
  end
`endif

  assign bus.in_ready   = in_ready;
  assign bus.out        = out_bit;
  assign bus.out_valid  = out_valid;
  assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance,
// expected bit streams written out by hand. Works with or without PISO_PARITY_EN.
module tb_piso_serializer;
`ifdef PISO_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  piso_serializer_if #(.WIDTH(8)) m_if ();
  piso_serializer_if #(.WIDTH(8)) l_if ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .bus(m_if.slave)
  );
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .bus(l_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic f_out(input bit sel);
    return sel ? l_if.out : m_if.out;
  endfunction
  function automatic logic f_ov(input bit sel);
    return sel ? l_if.out_valid : m_if.out_valid;
  endfunction
  function automatic logic f_rdy(input bit sel);
    return sel ? l_if.in_ready : m_if.in_ready;
  endfunction
  function automatic logic f_fd(input bit sel);
    return sel ? l_if.frame_done : m_if.frame_done;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin l_if.in_valid = v; l_if.data_in = d; end
    else     begin m_if.in_valid = v; m_if.data_in = d; end
  endtask

  task automatic set_srdy(input bit sel, input logic r);
    if (sel) l_if.ser_ready = r;
    else     m_if.ser_ready = r;
  endtask

  // Runs one frame starting at a falling edge. exp[0] is the first bit sent.
  // While in_ready is low the bench drives a junk word that must be ignored.
  task automatic do_frame(input string name, input bit sel, input logic [7:0] w,
                          input logic [0:8] exp, input bit present_w, input bit fd_first,
                          input int stall_at, input bit chain, input logic [7:0] w2);
    if (present_w) begin
      drive(sel, 1'b1, w);
      check({name, " accept_ready"}, f_rdy(sel), 1'b1);
      @(negedge clk);
    end
    for (int i = 0; i < FRAME; i++) begin
      if (i < FRAME - 1) drive(sel, 1'b1, ~w);
      else if (chain)    drive(sel, 1'b1, w2);
      else               drive(sel, 1'b0, 8'h00);
      if (i == stall_at) begin
        for (int s = 0; s < 3; s++) begin
          set_srdy(sel, 1'b0);
          check($sformatf("%s stall%0d out", name, s), f_out(sel), exp[i]);
          check($sformatf("%s stall%0d valid", name, s), f_ov(sel), 1'b1);
          check($sformatf("%s stall%0d ready", name, s), f_rdy(sel), 1'b0);
          check($sformatf("%s stall%0d done", name, s), f_fd(sel), 1'b0);
          @(negedge clk);
        end
        set_srdy(sel, 1'b1);
      end
      check($sformatf("%s bit%0d out", name, i), f_out(sel), exp[i]);
      check($sformatf("%s bit%0d valid", name, i), f_ov(sel), 1'b1);
      check($sformatf("%s bit%0d ready", name, i), f_rdy(sel), (i == FRAME - 1));
      check($sformatf("%s bit%0d done", name, i), f_fd(sel), (i == 0) && fd_first);
      @(negedge clk);
    end
    if (!chain) begin
      drive(sel, 1'b0, 8'h00);
      check({name, " end done"}, f_fd(sel), 1'b1);
      check({name, " end valid"}, f_ov(sel), 1'b0);
      check({name, " end out"}, f_out(sel), 1'b0);
      check({name, " end ready"}, f_rdy(sel), 1'b1);
      @(negedge clk);
      check({name, " done pulse"}, f_fd(sel), 1'b0);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    set_srdy(1'b0, 1'b1);
    set_srdy(1'b1, 1'b1);

    @(negedge clk);
    check("rst valid", f_ov(0), 1'b0);
    check("rst out", f_out(0), 1'b0);
    check("rst done", f_fd(0), 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    check("post-rst ready msb", f_rdy(0), 1'b1);
    check("post-rst ready lsb", f_rdy(1), 1'b1);
    @(negedge clk);

    // Ser_ready toggling with no frame in flight must have no effect.
    set_srdy(1'b0, 1'b0);
    check("idle srdy valid", f_ov(0), 1'b0);
    check("idle srdy ready", f_rdy(0), 1'b1);
    set_srdy(1'b0, 1'b1);

    do_frame("a5", 1'b0, 8'hA5, 9'b10100101_0, 1'b1, 1'b0, -1, 1'b0, 8'h00);
    do_frame("05lsb", 1'b1, 8'h05, 9'b10100000_0, 1'b1, 1'b0, -1, 1'b0, 8'h00);
    do_frame("a5stall", 1'b0, 8'hA5, 9'b10100101_0, 1'b1, 1'b0, 2, 1'b0, 8'h00);
    do_frame("b2b1", 1'b0, 8'hA5, 9'b10100101_0, 1'b1, 1'b0, -1, 1'b1, 8'h3C);
    do_frame("b2b2", 1'b0, 8'h3C, 9'b00111100_0, 1'b0, 1'b1, -1, 1'b0, 8'h00);
    do_frame("07", 1'b0, 8'h07, 9'b00000111_1, 1'b1, 1'b0, -1, 1'b0, 8'h00);

    // Reset in the middle of a frame.
    drive(1'b0, 1'b1, 8'hA5);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    check("mid bit4 out", f_out(0), 1'b0);
    check("mid bit4 valid", f_ov(0), 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid rst valid", f_ov(0), 1'b0);
    check("mid rst out", f_out(0), 1'b0);
    check("mid rst done", f_fd(0), 1'b0);
    @(negedge clk);
    check("mid rst done2", f_fd(0), 1'b0);
    reset_n = 1'b1;
    check("mid rst ready", f_rdy(0), 1'b1);
    do_frame("ff", 1'b0, 8'hFF, 9'b11111111_0, 1'b1, 1'b0, -1, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
